// File: rtl/pc_unit.sv
// pc_unit: RV32I fetch-stage program counter.
//   Holds the fetch PC and the previous PC. Picks the next PC by fixed
//   priority: trap > redirect (aligned / misaligned) > replay > stall >
//   halt_req > sequential increment. A small BOOT/RUN/HALT FSM gates
//   fetch and decides which inputs are honoured.
//   Optional return-address stack is compiled in when PC_RAS_EN is defined;
//   otherwise o_ras_top reads 0 and o_ras_empty reads 1.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_stall / i_replay       hold PC / reload PC from o_pc_prev
//   i_redirect_valid/_target taken branch or jump and its destination
//   i_trap_valid             exception/interrupt entry (to TRAP_VECTOR)
//   i_halt_req / i_resume    enter / leave HALT
//   i_ras_push / i_ras_pop   call / return (PC_RAS_EN only)
//   o_pc, o_pc_prev, o_pc_plus  fetch PC, previous PC, PC+INC
//   o_fetch_valid, o_halted  fetch qualifier, FSM in HALT
//   o_misalign_exc/_addr     one-cycle pulse and held offending target
//   o_ras_top, o_ras_empty   RAS top entry and empty flag
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int              INC          = 4,
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_stall,
    input  logic            i_replay,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_trap_valid,
    input  logic            i_halt_req,
    input  logic            i_resume,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_prev,
    output logic [XLEN-1:0] o_pc_plus,
    output logic            o_fetch_valid,
    output logic            o_halted,
    output logic            o_misalign_exc,
    output logic [XLEN-1:0] o_misalign_addr,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_empty
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    // Mask of target bits that must be zero; all-zero when ALIGN_BITS=0,
    // which turns the check off.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, r_pc_prev, r_misalign_addr;
    logic            r_misalign_exc;
    logic [XLEN-1:0] w_pc_plus;
    logic            w_active, w_run, w_tgt_mis;
    logic            w_trap, w_redir_ok, w_redir_bad, w_replay, w_hold, w_halt, w_inc;

    assign w_pc_plus = r_pc + XLEN'(INC);
    assign w_active  = (r_state != ST_BOOT);
    assign w_run     = (r_state == ST_RUN);
    assign w_tgt_mis = |(i_redirect_target & ALIGN_MASK);

    // Priority decode. Trap and redirect act in RUN and HALT; the rest only in RUN.
    assign w_trap      = w_active & i_trap_valid;
    assign w_redir_ok  = w_active & ~i_trap_valid & i_redirect_valid & ~w_tgt_mis;
    assign w_redir_bad = w_active & ~i_trap_valid & i_redirect_valid &  w_tgt_mis;
    assign w_replay    = w_run & ~i_trap_valid & ~i_redirect_valid & i_replay;
    assign w_hold      = w_run & ~i_trap_valid & ~i_redirect_valid & ~i_replay & i_stall;
    assign w_halt      = w_run & ~i_trap_valid & ~i_redirect_valid & ~i_replay & ~i_stall & i_halt_req;
    assign w_inc       = w_run & ~i_trap_valid & ~i_redirect_valid & ~i_replay & ~i_stall & ~i_halt_req;

    // ---- FSM: state register ----
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_BOOT;
        else     r_state <= w_state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN:  if (w_halt) w_state_nxt = ST_HALT;
            ST_HALT: if (i_trap_valid || i_redirect_valid || i_resume) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        o_fetch_valid = 1'b0;
        o_halted      = 1'b0;
        case (r_state)
            ST_RUN:  o_fetch_valid = ~i_stall;
            ST_HALT: o_halted      = 1'b1;
            default: ;
        endcase
    end

    // ---- PC datapath ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc            <= RESET_VECTOR;
            r_pc_prev       <= RESET_VECTOR;
            r_misalign_exc  <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign_exc <= w_redir_bad;
            if (w_trap || w_redir_bad) begin
                r_pc      <= TRAP_VECTOR;
                r_pc_prev <= r_pc;
            end else if (w_redir_ok) begin
                r_pc      <= i_redirect_target;
                r_pc_prev <= r_pc;
            end else if (w_replay) begin
                r_pc      <= r_pc_prev;   // pc_prev intentionally kept
            end else if (w_inc) begin
                r_pc      <= w_pc_plus;
                r_pc_prev <= r_pc;
            end
            if (w_redir_bad) r_misalign_addr <= i_redirect_target;
        end
    end

    assign o_pc            = r_pc;
    assign o_pc_prev       = r_pc_prev;
    assign o_pc_plus       = w_pc_plus;
    assign o_misalign_exc  = r_misalign_exc;
    assign o_misalign_addr = r_misalign_addr;

`ifdef PC_RAS_EN
    // Circular stack: r_top indexes the newest entry, r_cnt saturates at
    // RAS_DEPTH so a push when full silently drops the oldest entry.
    localparam int               PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);

    logic [RAS_DEPTH-1:0][XLEN-1:0] r_ras;
    logic [PTR_W-1:0]               r_top;
    logic [CNT_W-1:0]               r_cnt;
    logic                           w_push, w_pop;
    logic [PTR_W-1:0]               w_top_inc, w_top_dec;

    assign w_push    = w_run & i_ras_push;
    assign w_pop     = w_run & i_ras_pop;
    assign w_top_inc = (r_top == PTR_LAST) ? '0 : r_top + 1'b1;
    assign w_top_dec = (r_top == '0) ? PTR_LAST : r_top - 1'b1;

    always_ff @(posedge clk) begin
        if (rst || w_trap) begin
            r_ras <= '0;
            r_top <= '0;
            r_cnt <= '0;
        end else if (w_push && w_pop) begin
            r_ras[r_top] <= w_pc_plus;
        end else if (w_push) begin
            r_ras[w_top_inc] <= w_pc_plus;
            r_top            <= w_top_inc;
            if (r_cnt != CNT_W'(RAS_DEPTH)) r_cnt <= r_cnt + 1'b1;
        end else if (w_pop && (r_cnt != '0)) begin
            r_top <= w_top_dec;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_ras_empty = (r_cnt == '0);
    assign o_ras_top   = o_ras_empty ? '0 : r_ras[r_top];
`else
    logic w_unused;
    assign w_unused    = &{1'b0, i_ras_push, i_ras_pop, (RAS_DEPTH > 0)};
    assign o_ras_top   = '0;
    assign o_ras_empty = 1'b1;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus a randomized run, all checked against
// a behavioural model of the PC unit (queue-based RAS when PC_RAS_EN is set).
module tb_pc_unit;
    localparam logic [31:0] TV = 32'h0000_0100;
    localparam int BOOT = 0, RUN = 1, HALT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, replay, redir, trap, halt, resume, push, pop;
    logic [31:0] tgt;
    logic [31:0] pc, pc_prev, pc_plus, maddr, ras_top;
    logic        fv, halted, mis, ras_empty;

    int checks = 0, failures = 0;

    // behavioural model state
    logic [31:0] m_pc, m_prev, m_maddr;
    logic        m_mis;
    int          m_st;
    logic [31:0] m_ras[$];

    pc_unit dut (
        .clk(clk), .rst(rst), .i_stall(stall), .i_replay(replay),
        .i_redirect_valid(redir), .i_redirect_target(tgt), .i_trap_valid(trap),
        .i_halt_req(halt), .i_resume(resume), .i_ras_push(push), .i_ras_pop(pop),
        .o_pc(pc), .o_pc_prev(pc_prev), .o_pc_plus(pc_plus), .o_fetch_valid(fv),
        .o_halted(halted), .o_misalign_exc(mis), .o_misalign_addr(maddr),
        .o_ras_top(ras_top), .o_ras_empty(ras_empty)
    );

    task automatic clear_inputs();
        rst = 0; stall = 0; replay = 0; redir = 0; trap = 0;
        halt = 0; resume = 0; push = 0; pop = 0; tgt = 0;
    endtask

    // Advance one clock: model computes the next state from the applied
    // inputs, then the DUT is sampled 1 time unit after the edge.
    task automatic tick();
        logic [31:0] n_pc, n_prev, n_maddr;
        logic        n_mis;
        int          n_st;
        n_pc = m_pc; n_prev = m_prev; n_maddr = m_maddr; n_mis = 1'b0; n_st = m_st;
        if (rst) begin
            n_pc = 0; n_prev = 0; n_maddr = 0; n_st = BOOT;
            m_ras.delete();
        end else if (m_st == BOOT) begin
            n_st = RUN;
        end else begin
            if (trap || redir) begin
                n_prev = m_pc;
                n_st   = RUN;
                if (trap) n_pc = TV;
                else if (tgt % 4 == 0) n_pc = tgt;
                else begin n_pc = TV; n_mis = 1'b1; n_maddr = tgt; end
            end else if (m_st == HALT) begin
                if (resume) n_st = RUN;
            end else if (replay) begin
                n_pc = m_prev;
            end else if (!stall && halt) begin
                n_st = HALT;
            end else if (!stall) begin
                n_prev = m_pc; n_pc = m_pc + 4;
            end
`ifdef PC_RAS_EN
            if (trap) m_ras.delete();
            else if (m_st == RUN) begin
                if (push && pop) begin
                    if (m_ras.size() > 0) m_ras[m_ras.size()-1] = m_pc + 4;
                end else if (push) begin
                    m_ras.push_back(m_pc + 4);
                    if (m_ras.size() > 4) void'(m_ras.pop_front());
                end else if (pop && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
`endif
        end
        @(posedge clk); #1;
        m_pc = n_pc; m_prev = n_prev; m_maddr = n_maddr; m_mis = n_mis; m_st = n_st;
    endtask

    task automatic goto_pc(input logic [31:0] a);
        redir = 1; tgt = a; tick(); redir = 0;
    endtask

    task automatic test_reset();
        clear_inputs(); rst = 1; tick(); tick(); rst = 0;
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        checks++; if (pc_prev !== 32'h0) begin failures++; $display("FAIL reset_pc_prev got=%h exp=%h", pc_prev, 32'h0); end
        checks++; if (fv !== 1'b0) begin failures++; $display("FAIL reset_fetch_valid got=%b exp=0", fv); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (mis !== 1'b0) begin failures++; $display("FAIL reset_misalign_exc got=%b exp=0", mis); end
        checks++; if (maddr !== 32'h0) begin failures++; $display("FAIL reset_misalign_addr got=%h exp=0", maddr); end
        checks++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin failures++; $display("FAIL reset_ras got=%b/%h exp=1/0", ras_empty, ras_top); end
    endtask

    task automatic test_sequential();
        tick();  // BOOT -> RUN, pc held
        checks++; if (pc !== 32'h0 || fv !== 1'b1) begin failures++; $display("FAIL boot_exit got=%h/%b exp=0/1", pc, fv); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc !== 32'(4*i) || pc_prev !== 32'(4*(i-1))) begin failures++; $display("FAIL seq_pc%0d got=%h/%h exp=%h/%h", i, pc, pc_prev, 32'(4*i), 32'(4*(i-1))); end
            checks++; if (pc_plus !== 32'(4*i+4)) begin failures++; $display("FAIL seq_pc_plus%0d got=%h exp=%h", i, pc_plus, 32'(4*i+4)); end
        end
    endtask

    task automatic test_stall_redirect();
        goto_pc(32'h10);
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc !== 32'h10 || fv !== 1'b0) begin failures++; $display("FAIL stall_hold%0d got=%h/%b exp=10/0", i, pc, fv); end
        end
        redir = 1; tgt = 32'h200; tick(); redir = 0; stall = 0;
        checks++; if (pc !== 32'h200 || pc_prev !== 32'h10) begin failures++; $display("FAIL stall_redirect got=%h/%h exp=200/10", pc, pc_prev); end
    endtask

    task automatic test_misalign();
        goto_pc(32'h202);
        checks++; if (pc !== TV || mis !== 1'b1 || maddr !== 32'h202) begin failures++; $display("FAIL misalign_take got=%h/%b/%h exp=100/1/202", pc, mis, maddr); end
        tick();
        checks++; if (mis !== 1'b0 || maddr !== 32'h202 || pc !== 32'h104) begin failures++; $display("FAIL misalign_pulse got=%b/%h/%h exp=0/202/104", mis, maddr, pc); end
        trap = 1; redir = 1; tgt = 32'h300; tick(); trap = 0; redir = 0;
        checks++; if (pc !== TV || mis !== 1'b0) begin failures++; $display("FAIL trap_over_redirect got=%h/%b exp=100/0", pc, mis); end
        goto_pc(32'hFFFF_FFFC); tick();
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc); end
    endtask

    task automatic test_replay();
        goto_pc(32'h1C); tick();
        replay = 1; tick(); replay = 0;
        checks++; if (pc !== 32'h1C || pc_prev !== 32'h1C) begin failures++; $display("FAIL replay got=%h/%h exp=1c/1c", pc, pc_prev); end
        tick();
        checks++; if (pc !== 32'h20) begin failures++; $display("FAIL replay_after got=%h exp=20", pc); end
    endtask

    task automatic test_halt();
        goto_pc(32'h40);
        halt = 1; tick(); halt = 0;
        checks++; if (halted !== 1'b1 || pc !== 32'h40 || fv !== 1'b0) begin failures++; $display("FAIL halt_enter got=%b/%h/%b exp=1/40/0", halted, pc, fv); end
        for (int i = 0; i < 3; i++) begin
            stall = i[0]; replay = ~i[0]; halt = 1; tick();
            checks++; if (halted !== 1'b1 || pc !== 32'h40) begin failures++; $display("FAIL halt_hold%0d got=%b/%h exp=1/40", i, halted, pc); end
        end
        clear_inputs(); resume = 1; tick(); resume = 0;
        checks++; if (halted !== 1'b0 || pc !== 32'h40) begin failures++; $display("FAIL resume got=%b/%h exp=0/40", halted, pc); end
        tick();
        checks++; if (pc !== 32'h44) begin failures++; $display("FAIL resume_next got=%h exp=44", pc); end
        halt = 1; tick(); halt = 0;
        rst = 1; tick(); rst = 0;
        checks++; if (pc !== 32'h0 || halted !== 1'b0 || fv !== 1'b0) begin failures++; $display("FAIL halt_reset got=%h/%b/%b exp=0/0/0", pc, halted, fv); end
        tick();
    endtask

    task automatic test_ras();
        logic [31:0] exp_top [4];
        logic        exp_emp [4];
        rst = 1; tick(); rst = 0; tick();
        push = 1;
        for (int i = 0; i < 5; i++) tick();
        push = 0;
`ifdef PC_RAS_EN
        exp_top = '{32'h10, 32'hC, 32'h8, 32'h0};
        exp_emp = '{1'b0, 1'b0, 1'b0, 1'b1};
        checks++; if (ras_top !== 32'h14 || ras_empty !== 1'b0) begin failures++; $display("FAIL ras_push got=%h/%b exp=14/0", ras_top, ras_empty); end
`else
        exp_top = '{32'h0, 32'h0, 32'h0, 32'h0};
        exp_emp = '{1'b1, 1'b1, 1'b1, 1'b1};
        checks++; if (ras_top !== 32'h0 || ras_empty !== 1'b1) begin failures++; $display("FAIL ras_off got=%h/%b exp=0/1", ras_top, ras_empty); end
`endif
        pop = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ras_top !== exp_top[i > 3 ? 3 : i] || ras_empty !== exp_emp[i > 3 ? 3 : i]) begin failures++; $display("FAIL ras_pop%0d got=%h/%b exp=%h/%b", i, ras_top, ras_empty, exp_top[i > 3 ? 3 : i], exp_emp[i > 3 ? 3 : i]); end
        end
        pop = 0;
    endtask

    task automatic test_random();
        logic [31:0] e_top;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) == 0);
            trap   = ($urandom_range(0, 15) == 0);
            redir  = ($urandom_range(0, 5) == 0);
            tgt    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            replay = ($urandom_range(0, 7) == 0);
            stall  = ($urandom_range(0, 3) == 0);
            halt   = ($urandom_range(0, 11) == 0);
            resume = ($urandom_range(0, 3) == 0);
            push   = ($urandom_range(0, 3) == 0);
            pop    = ($urandom_range(0, 3) == 0);
            tick();
            e_top = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
            checks++; if (pc !== m_pc) begin failures++; $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
            checks++; if (pc_prev !== m_prev) begin failures++; $display("FAIL rnd_pc_prev[%0d] got=%h exp=%h", i, pc_prev, m_prev); end
            checks++; if (pc_plus !== m_pc + 32'd4) begin failures++; $display("FAIL rnd_pc_plus[%0d] got=%h exp=%h", i, pc_plus, m_pc + 32'd4); end
            checks++; if (fv !== (m_st == RUN && !stall)) begin failures++; $display("FAIL rnd_fetch_valid[%0d] got=%b exp=%b", i, fv, (m_st == RUN && !stall)); end
            checks++; if (halted !== (m_st == HALT)) begin failures++; $display("FAIL rnd_halted[%0d] got=%b exp=%b", i, halted, (m_st == HALT)); end
            checks++; if (mis !== m_mis || maddr !== m_maddr) begin failures++; $display("FAIL rnd_misalign[%0d] got=%b/%h exp=%b/%h", i, mis, maddr, m_mis, m_maddr); end
            checks++; if (ras_top !== e_top || ras_empty !== (m_ras.size() == 0)) begin failures++; $display("FAIL rnd_ras[%0d] got=%h/%b exp=%h/%b", i, ras_top, ras_empty, e_top, (m_ras.size() == 0)); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        m_pc = 0; m_prev = 0; m_maddr = 0; m_mis = 0; m_st = BOOT;
        test_reset();
        test_sequential();
        test_stall_redirect();
        test_misalign();
        test_replay();
        test_halt();
        test_ras();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
